// File: rtl/vga_fetch_pkg.sv
// Shared types and defaults for the frame fetch arbiter: FSM states,
// read-slot owners, in-flight tag layout and the tag-kill helper.
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_DRW  = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

    localparam int unsigned DEF_PIX_PER_FRAME = 307200;
    localparam int unsigned DEF_BASE_ADDR     = 0;

    // Drops a display-owned tag when a frame restart discards its data.
    function automatic rd_tag_t tag_kill_disp(input rd_tag_t t, input logic inv);
        rd_tag_t r;
        r = t;
        if (inv && (t.owner == OWN_DISP))
            r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of {valid, owner} tags that tracks ROM reads
// in flight; display tags can be invalidated synchronously on restart.
module rd_tag_pipe
    import vga_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    input  logic    inv_disp,
    output rd_tag_t tag_out,
    output logic    disp_pending
);

    rd_tag_t [DEPTH-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= tag_kill_disp(tag_in, inv_disp);
            for (int unsigned i = 1; i < DEPTH; i++)
                stage[i] <= tag_kill_disp(stage[i-1], inv_disp);
        end
    end

    assign tag_out = stage[DEPTH-1];

    always_comb begin
        disp_pending = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (stage[i].valid && (stage[i].owner == OWN_DISP))
                disp_pending = 1'b1;
    end

endmodule

// File: rtl/frame_fetch_arbiter.sv
// ROM read-port arbiter between display refill and draw reads, with
// in-flight tagging. FETCH_STATS_EN enables the frame/stall counters.
module frame_fetch_arbiter
    import vga_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W        = 24,
    parameter int unsigned DATA_W        = 24,
    parameter int unsigned PIX_PER_FRAME = DEF_PIX_PER_FRAME,
    parameter int unsigned BASE_ADDR     = DEF_BASE_ADDR,
    parameter int unsigned RD_LAT        = 2,
    parameter int unsigned DRW_MAX_WAIT  = 8
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    input  logic              fifo_prog_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wdata,
    input  logic              drw_req,
    input  logic [ADDR_W-1:0] drw_addr,
    output logic              drw_gnt,
    output logic              drw_rvalid,
    output logic [DATA_W-1:0] drw_rdata,
    output logic              fetch_busy,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drw_stall_cnt
);

    localparam int unsigned PIX_W  = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;
    localparam int unsigned WAIT_W = (DRW_MAX_WAIT > 0) ? $clog2(DRW_MAX_WAIT + 1) : 1;

    fetch_state_t      state;
    logic              busy_q;
    logic [PIX_W-1:0]  pixel_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              disp_elig, force_drw, grant_drw, issue_disp;
    logic              last_pix, inv_disp, disp_pending;
    logic [ADDR_W-1:0] disp_addr;
    rd_tag_t           tag_in, tag_out;

    // A restarting frame_start takes the display slot for one cycle so that
    // a pending draw is honoured and new display reads follow a clean pipe.
    always_comb begin
        disp_elig    = (state == ST_FETCH) && !fifo_prog_full && !frame_start;
        force_drw    = (wait_cnt >= WAIT_W'(DRW_MAX_WAIT));
        grant_drw    = drw_req && (!disp_elig || force_drw);
        issue_disp   = disp_elig && !grant_drw;
        last_pix     = (pixel_idx == PIX_W'(PIX_PER_FRAME - 1));
        inv_disp     = frame_start && (state != ST_IDLE);
        disp_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(pixel_idx);
        tag_in.valid = grant_drw || issue_disp;
        tag_in.owner = grant_drw ? OWN_DRW : OWN_DISP;
    end

    assign drw_gnt    = grant_drw;
    assign fetch_busy = busy_q;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy_q    <= 1'b0;
            pixel_idx <= '0;
            wait_cnt  <= '0;
            rom_addr  <= ADDR_W'(BASE_ADDR);
        end else begin
            if (grant_drw)
                rom_addr <= drw_addr;
            else if (issue_disp)
                rom_addr <= disp_addr;

            if (grant_drw)
                wait_cnt <= '0;
            else if (drw_req)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state     <= ST_FETCH;
                        busy_q    <= 1'b1;
                        pixel_idx <= '0;
                    end
                end
                ST_FETCH: begin
                    if (frame_start) begin
                        pixel_idx <= '0;
                    end else if (issue_disp) begin
                        if (last_pix) begin
                            state <= ST_DRAIN;
                        end else begin
                            pixel_idx <= pixel_idx + PIX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (frame_start) begin
                        state     <= ST_FETCH;
                        pixel_idx <= '0;
                    end else if (!disp_pending) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk          (clk_100mhz),
        .rst_n        (rst_n),
        .tag_in       (tag_in),
        .inv_disp     (inv_disp),
        .tag_out      (tag_out),
        .disp_pending (disp_pending)
    );

    // The exiting tag is killed too, so a restart drops every display read in flight.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_en <= 1'b0;
            fifo_wdata <= '0;
            drw_rvalid <= 1'b0;
            drw_rdata  <= '0;
        end else begin
            fifo_wr_en <= tag_out.valid && (tag_out.owner == OWN_DISP) && !inv_disp;
            drw_rvalid <= tag_out.valid && (tag_out.owner == OWN_DRW);
            if (tag_out.valid && (tag_out.owner == OWN_DISP) && !inv_disp)
                fifo_wdata <= rom_rdata;
            if (tag_out.valid && (tag_out.owner == OWN_DRW))
                drw_rdata <= rom_rdata;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] stall_cnt_q;
    logic        frame_done;

    assign frame_done = (state == ST_DRAIN) && !frame_start && !disp_pending;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (frame_done)
                frame_cnt_q <= frame_cnt_q + 16'd1;
            if (drw_req && !grant_drw)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign frame_cnt     = frame_cnt_q;
    assign drw_stall_cnt = stall_cnt_q;
`else
    assign frame_cnt     = '0;
    assign drw_stall_cnt = '0;
`endif

endmodule
